// File: rtl/reg_wb_queue.sv
// Register-file write-port owner: merges same-cycle ALU results with deferred
// LSU results held in a small FIFO, and tracks pending destinations for decode stall.
module reg_wb_queue #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int QUEUE_DEPTH   = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_we,
  input  logic [ADDRESS_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_wd,
  output logic                     alu_hold,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDRESS_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0]    lsu_wd,
  input  logic                     issue_en,
  input  logic [ADDRESS_WIDTH-1:0] issue_rd,
  input  logic [ADDRESS_WIDTH-1:0] chk_rs1,
  input  logic [ADDRESS_WIDTH-1:0] chk_rs2,
  input  logic [ADDRESS_WIDTH-1:0] chk_rd,
  output logic                     stall,
  output logic                     WE3,
  output logic [ADDRESS_WIDTH-1:0] AD3,
  output logic [DATA_WIDTH-1:0]    WD3
);

  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int REGS   = 1 << ADDRESS_WIDTH;

  logic [ADDRESS_WIDTH-1:0] q_rd [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0]    q_wd [QUEUE_DEPTH];
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic [CNT_W-1:0]         count;
  logic [SCNT_W-1:0]        starve_cnt;
  logic [REGS-1:0]          pending;
  logic [REGS-1:0]          pending_next;

  logic not_empty;
  logic full;
  logic alu_wr;
  logic starved;
  logic pop;
  logic push;

  assign not_empty = (count != '0);
  assign full      = (count == CNT_W'(QUEUE_DEPTH));
  assign alu_wr    = alu_we && (alu_rd != '0);
  assign starved   = not_empty && (starve_cnt == SCNT_W'(STARVE_LIMIT));
  assign lsu_ready = !rst && !full;
  // Beats to x0 still complete the handshake but never occupy a slot.
  assign push      = lsu_valid && lsu_ready && (lsu_rd != '0);

  // ALU wins the port unless the FIFO head has waited STARVE_LIMIT cycles.
  always_comb begin
    // NOTE: every output gets a default before the branches so no path infers a latch.
    WE3      = 1'b0;
    AD3      = '0;
    WD3      = '0;
    alu_hold = 1'b0;
    pop      = 1'b0;
    if (!rst) begin
      if (alu_wr && !starved) begin
        WE3 = 1'b1;
        AD3 = alu_rd;
        WD3 = alu_wd;
      end else if (not_empty) begin
        WE3      = 1'b1;
        AD3      = q_rd[head];
        WD3      = q_wd[head];
        alu_hold = alu_wr;
        pop      = 1'b1;
      end
    end
  end

  // A same-cycle issue to the register being retired must leave it pending.
  always_comb begin
    pending_next = pending;
    if (pop) pending_next[q_rd[head]] = 1'b0;
    if (issue_en && (issue_rd != '0)) pending_next[issue_rd] = 1'b1;
  end

  assign stall = !rst && (((chk_rs1 != '0) && pending[chk_rs1]) ||
                          ((chk_rs2 != '0) && pending[chk_rs2]) ||
                          ((chk_rd  != '0) && pending[chk_rd]));

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
      pending    <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop || !not_empty)
        starve_cnt <= '0;
      else if (starve_cnt != SCNT_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
      pending <= pending_next;
    end
  end

  // NOTE: FIFO storage has no reset; count/head/tail alone decide which slots are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail] <= lsu_rd;
      q_wd[tail] <= lsu_wd;
    end
  end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Self-checking bench for reg_wb_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_reg_wb_queue;

  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int DEPTH  = 4;
  localparam int STARVE = 8;

  logic          clk;
  logic          rst;
  logic          alu_we;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_wd;
  logic          alu_hold;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_wd;
  logic          issue_en;
  logic [AW-1:0] issue_rd;
  logic [AW-1:0] chk_rs1;
  logic [AW-1:0] chk_rs2;
  logic [AW-1:0] chk_rd;
  logic          stall;
  logic          WE3;
  logic [AW-1:0] AD3;
  logic [DW-1:0] WD3;

  reg_wb_queue #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .QUEUE_DEPTH(DEPTH), .STARVE_LIMIT(STARVE)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_we(alu_we), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_hold(alu_hold),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .stall(stall),
    .WE3(WE3), .AD3(AD3), .WD3(WD3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] wd;
  } ent_t;

  // Reference model: an ordered list of deferred results, a pending flag per
  // register, and a wait counter for the oldest result.
  ent_t q[$];
  bit   m_pend[32];
  int   m_starve;
  int   cyc;
  int   total_cnt;
  int   pass_cnt;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  task automatic set_idle();
    rst = 1'b0; alu_we = 1'b0; alu_rd = '0; alu_wd = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_wd = '0;
    issue_en = 1'b0; issue_rd = '0;
    chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
  endtask

  // One clock: predict outputs from the model, compare, then advance the model.
  task automatic step();
    logic          e_we, e_hold, e_ready, e_stall;
    logic [AW-1:0] e_ad;
    logic [DW-1:0] e_wd;
    bit            alu_wr, starved, pop, push;
    int            old_size;
    #1;
    e_we = 0; e_hold = 0; e_ready = 0; e_stall = 0; e_ad = '0; e_wd = '0;
    pop = 0; push = 0;
    old_size = q.size();
    alu_wr  = alu_we && (alu_rd != 0);
    starved = (old_size != 0) && (m_starve == STARVE);
    if (!rst) begin
      e_ready = (old_size != DEPTH);
      e_stall = (chk_rs1 != 0 && m_pend[chk_rs1]) || (chk_rs2 != 0 && m_pend[chk_rs2]) ||
                (chk_rd != 0 && m_pend[chk_rd]);
      if (alu_wr && !starved) begin
        e_we = 1; e_ad = alu_rd; e_wd = alu_wd;
      end else if (old_size != 0) begin
        e_we = 1; e_ad = q[0].rd; e_wd = q[0].wd; e_hold = alu_wr; pop = 1;
      end
      push = lsu_valid && e_ready && (lsu_rd != 0);
    end
    chk("WE3", 32'(WE3), 32'(e_we));
    chk("AD3", 32'(AD3), 32'(e_ad));
    chk("WD3", WD3, e_wd);
    chk("alu_hold", 32'(alu_hold), 32'(e_hold));
    chk("lsu_ready", 32'(lsu_ready), 32'(e_ready));
    chk("stall", 32'(stall), 32'(e_stall));
    @(posedge clk);
    if (rst) begin
      q.delete();
      foreach (m_pend[i]) m_pend[i] = 0;
      m_starve = 0;
    end else begin
      if (pop) begin
        m_pend[q[0].rd] = 0;
        void'(q.pop_front());
      end
      if (issue_en && issue_rd != 0) m_pend[issue_rd] = 1;
      if (push) q.push_back('{lsu_rd, lsu_wd});
      if (pop || old_size == 0) m_starve = 0;
      else if (m_starve < STARVE) m_starve++;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    total_cnt = 0; pass_cnt = 0; cyc = 0; m_starve = 0;
    foreach (m_pend[i]) m_pend[i] = 0;
    set_idle();
    rst = 1'b1;
    @(negedge clk);

    // 1. Reset for one cycle, then idle with a sweep of check registers.
    step();
    set_idle();
    for (int r = 0; r < 8; r++) begin
      chk_rs1 = AW'(r); chk_rs2 = AW'(r + 8); chk_rd = AW'(31 - r);
      step();
    end

    // 2. ALU-only write.
    set_idle();
    alu_we = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF;
    step();

    // 3. Load path: issue, observe stall, deliver the result, watch it retire.
    set_idle();
    issue_en = 1'b1; issue_rd = 5'd7;
    step();
    set_idle();
    chk_rs1 = 5'd7;
    step();
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = 32'h1234;
    step();
    lsu_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // 4. Fill the FIFO while the ALU hogs the port until the head starves.
    set_idle();
    for (int i = 0; i < 4; i++) begin
      issue_en = 1'b1; issue_rd = AW'(10 + i);
      step();
    end
    set_idle();
    alu_we = 1'b1; alu_rd = 5'd3; chk_rs2 = 5'd12;
    for (int i = 0; i < 4; i++) begin
      alu_wd = 32'h100 + 32'(i);
      lsu_valid = 1'b1; lsu_rd = AW'(10 + i); lsu_wd = 32'hA000 + 32'(i);
      step();
    end
    lsu_valid = 1'b1; lsu_rd = 5'd14; lsu_wd = 32'hBAD;
    for (int i = 0; i < 14; i++) begin
      alu_wd = 32'h200 + 32'(i);
      step();
    end
    set_idle();
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk("drained", 32'(q.size()), 32'd0);

    // 5. x0 protection on both ALU and LSU sides.
    alu_we = 1'b1; alu_rd = '0; alu_wd = 32'hFFFF_FFFF;
    lsu_valid = 1'b1; lsu_rd = '0; lsu_wd = 32'h5555;
    issue_en = 1'b1; issue_rd = '0;
    step();
    step();
    set_idle();
    step();

    // 6. Reset with three entries queued and two registers pending.
    issue_en = 1'b1; issue_rd = 5'd20;
    step();
    issue_rd = 5'd21;
    step();
    set_idle();
    alu_we = 1'b1; alu_rd = 5'd2;
    for (int i = 0; i < 3; i++) begin
      alu_wd = 32'h300 + 32'(i);
      lsu_valid = 1'b1; lsu_rd = AW'(20 + i); lsu_wd = 32'hC000 + 32'(i);
      step();
    end
    set_idle();
    chk_rs1 = 5'd20; chk_rs2 = 5'd21;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Random traffic, including occasional resets and x0 destinations.
    for (int n = 0; n < 500; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      alu_we    = 1'($urandom_range(0, 1));
      alu_rd    = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(1, 31));
      alu_wd    = $urandom;
      issue_en  = ($urandom_range(0, 2) == 0);
      issue_rd  = AW'($urandom_range(0, 15));
      lsu_valid = ($urandom_range(0, 2) == 0);
      lsu_rd    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 15));
      lsu_wd    = $urandom;
      chk_rs1   = AW'($urandom_range(0, 15));
      chk_rs2   = AW'($urandom_range(0, 15));
      chk_rd    = AW'($urandom_range(0, 15));
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
